hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised hazard, forwarding and flush controller for the 16-bit five-stage pipeline (IF/ID/EX/MEM/WB). It sits beside the register file and pipeline registers. It replaces the fixed single-cycle load-use stall logic with four functions: a configurable-latency stall FSM, EX/MEM and MEM/WB forwarding selects, multi-bubble flush on redirects, and a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_AW, 4: register address width. Register 0 is never a hazard source.
- LOAD_LAT, 1: stall cycles per load-use hazard. Legal range 1..3.
- FLUSH_DEPTH, 2: cycles of IF/ID flush per redirect. Legal range 1..3.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- d_valid  in  1  ID stage holds a real instruction.
- d_raddr1, d_raddr2  in  REG_AW  ID source register addresses.
- d_use1, d_use2  in  1  the matching source is actually read.
- e_valid, e_wen, e_is_load  in  1  EX stage status.
- e_waddr  in  REG_AW  EX destination register.
- m_valid, m_wen  in  1  MEM stage status.
- m_waddr  in  REG_AW  MEM destination register.
- w_wen  in  1  WB write enable.
- w_waddr  in  REG_AW  WB destination register.
- redirect  in  1  taken branch, JAL, JR or EXEC resolved this cycle.
- perf_clr  in  1  synchronous clear of stall_cycles.
- pc_stall, ifid_stall  out  1  hold PC and IF/ID.
- idex_bubble  out  1  insert a NOP into ID/EX.
- ifid_flush, idex_flush  out  1  squash IF/ID and ID/EX contents.
- fwd1_sel, fwd2_sel  out  2  ALU operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- busy  out  1  FSM not in IDLE.
- stall_cycles  out  CNT_W  count of cycles with pc_stall high.

## Operation
- **hit(x, src):** x_valid & x_wen & x_waddr==src & src!=0 & use.
- **Load-use detect (LU):** d_valid & e_is_load & hit(e, d_raddr1 or d_raddr2).
- **Forwarding:**
  - fwd*_sel = 01 if the source hits in EX/MEM (m_*).
  - Otherwise 10 if it hits w_* (w_wen & w_waddr==src & src!=0).
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- **FSM states:** IDLE, LDSTALL, FLUSH. Down-counter cnt, 2 bits.
- **IDLE:**
  - If redirect: assert ifid_flush and idex_flush. If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-2.
  - Else if LU: assert pc_stall, ifid_stall and idex_bubble. If LOAD_LAT>1, go to LDSTALL with cnt=LOAD_LAT-2.
- **LDSTALL:**
  - Assert pc_stall, ifid_stall and idex_bubble.
  - Return to IDLE when cnt==0; otherwise decrement cnt.
  - A redirect aborts the stall: behave as the IDLE redirect case, stall outputs low that cycle.
- **FLUSH:**
  - Assert ifid_flush only.
  - Return to IDLE when cnt==0; otherwise decrement cnt.
  - A new redirect reloads cnt=FLUSH_DEPTH-2 (minimum 0) and asserts idex_flush.
  - LU is ignored while in FLUSH.
- **Priority:** redirect > load-use stall > normal flow. Stall and flush outputs are never high in the same cycle.
- **stall_cycles:**
  - Increments every cycle pc_stall is high.
  - Saturates at all-ones.
  - perf_clr wins over increment.

## Timing
- While rst is low:
  - State is IDLE and cnt=0.
  - stall_cycles=0.
  - All stall and flush outputs are 0, busy=0, fwd*_sel=00.
- Reset release mid-stall or mid-flush: the next cycle starts in IDLE. No residual bubbles.
- Stall, flush and forwarding outputs are combinational from current inputs and registered state. They are valid in the same cycle as detection.
- **Load-use:** exactly LOAD_LAT consecutive stall cycles, starting in the detection cycle. LU is re-evaluated in IDLE on the following cycle.
- **Redirect:**
  - idex_flush for 1 cycle.
  - ifid_flush for FLUSH_DEPTH cycles, starting in the redirect cycle.
- **busy** is registered: high exactly in cycles where the state is not IDLE.

## Structure
- **Shared package** `pipe_pkg`:
  - FSM state enum {IDLE, LDSTALL, FLUSH}.
  - fwd select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_AW default.
- **Sub-module** `fwd_sel`: one instance per source operand; pure combinational priority compare.
- The FSM, counter and perf counter live in hazard_ctrl.

## Test plan
- LOAD_LAT=1: load to r3 in EX, ID reads r3 (d_use1=1) -> pc_stall, ifid_stall and idex_bubble for 1 cycle; busy stays 0; stall_cycles=1.
- LOAD_LAT=3, same hazard -> 3 stall cycles. Redirect asserted in the 2nd stall cycle -> stall drops that cycle, idex_flush=1, ifid_flush held FLUSH_DEPTH cycles.
- Forwarding:
  - m_waddr=5 and w_waddr=5, d_raddr2=5 -> fwd2_sel=01.
  - Drop m_wen -> fwd2_sel=10.
  - d_raddr2=0 -> fwd2_sel=00.
- FLUSH_DEPTH=3: redirect, then a second redirect 1 cycle later -> ifid_flush high for 4 consecutive cycles, idex_flush high in both redirect cycles.
- rst driven low during LDSTALL -> all outputs 0 immediately (asynchronous); after release, no stall without a new hazard.
- stall_cycles preset near 0xFFFF by forcing 65540 stall cycles -> saturates at 0xFFFF. perf_clr together with a stall -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM states, forwarding selects, counter preload helper.
// Pure declarations, no logic; no flow control of its own.
package pipe_pkg;

   localparam int REG_AW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // The detection/redirect cycle itself covers one cycle and the exit cycle another,
   // so the down-counter preload is n-2, floored at 0.
   function automatic logic [1:0] cnt_init(input int n);
      return (n > 2) ? 2'(n - 2) : 2'd0;
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB beats the register file; register 0 never forwards.
// Purely combinational, zero latency; no backpressure.
module fwd_sel import pipe_pkg::*; #(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] i_src,
   input  logic              i_m_valid,
   input  logic              i_m_wen,
   input  logic [REG_AW-1:0] i_m_waddr,
   input  logic              i_w_wen,
   input  logic [REG_AW-1:0] i_w_waddr,
   output logic [1:0]        o_sel
);

   logic w_src_nz;
   logic w_m_hit;
   logic w_w_hit;

   assign w_src_nz = (i_src != '0);
   assign w_m_hit  = i_m_valid & i_m_wen & (i_m_waddr == i_src) & w_src_nz;
   assign w_w_hit  = i_w_wen & (i_w_waddr == i_src) & w_src_nz;

   always_comb begin
      if (w_m_hit) begin
         o_sel = FWD_MEM;
      end else if (w_w_hit) begin
         o_sel = FWD_WB;
      end else begin
         o_sel = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall FSM, redirect flush sequencing, operand forwarding and a saturating stall counter.
// Stall/flush/forward outputs are same-cycle combinational; busy and stall_cycles are registered.
module hazard_ctrl import pipe_pkg::*; #(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_valid,
   input  logic [REG_AW-1:0] d_raddr1,
   input  logic [REG_AW-1:0] d_raddr2,
   input  logic              d_use1,
   input  logic              d_use2,
   input  logic              e_valid,
   input  logic              e_wen,
   input  logic              e_is_load,
   input  logic [REG_AW-1:0] e_waddr,
   input  logic              m_valid,
   input  logic              m_wen,
   input  logic [REG_AW-1:0] m_waddr,
   input  logic              w_wen,
   input  logic [REG_AW-1:0] w_waddr,
   input  logic              redirect,
   input  logic              perf_clr,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic [1:0]        fwd1_sel,
   output logic [1:0]        fwd2_sel,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam logic [1:0] LD_CNT   = cnt_init(LOAD_LAT);
   localparam logic [1:0] FL_CNT   = cnt_init(FLUSH_DEPTH);
   localparam bit         LD_MULTI = (LOAD_LAT > 1);
   localparam bit         FL_MULTI = (FLUSH_DEPTH > 1);

   hz_state_t        r_state;
   hz_state_t        w_nxt_state;
   logic [1:0]       r_cnt;
   logic [1:0]       w_nxt_cnt;
   logic             r_busy;
   logic [CNT_W-1:0] r_stall_cycles;

   logic       w_hit1;
   logic       w_hit2;
   logic       w_lu;
   logic       w_stall;
   logic       w_ifid_flush;
   logic       w_idex_flush;
   logic [1:0] w_fwd1;
   logic [1:0] w_fwd2;

   assign w_hit1 = e_valid & e_wen & (e_waddr == d_raddr1) & (d_raddr1 != '0) & d_use1;
   assign w_hit2 = e_valid & e_wen & (e_waddr == d_raddr2) & (d_raddr2 != '0) & d_use2;
   assign w_lu   = d_valid & e_is_load & (w_hit1 | w_hit2);

   fwd_sel #(.REG_AW(REG_AW)) u_fwd1 (
      .i_src     (d_raddr1),
      .i_m_valid (m_valid),
      .i_m_wen   (m_wen),
      .i_m_waddr (m_waddr),
      .i_w_wen   (w_wen),
      .i_w_waddr (w_waddr),
      .o_sel     (w_fwd1)
   );

   fwd_sel #(.REG_AW(REG_AW)) u_fwd2 (
      .i_src     (d_raddr2),
      .i_m_valid (m_valid),
      .i_m_wen   (m_wen),
      .i_m_waddr (m_waddr),
      .i_w_wen   (w_wen),
      .i_w_waddr (w_waddr),
      .o_sel     (w_fwd2)
   );

   // Redirect outranks any stall, so stall and flush can never be high together.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_cnt    = r_cnt;
      w_stall      = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      case (r_state)
         IDLE, LDSTALL: begin
            if (redirect) begin
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
               w_nxt_state  = FL_MULTI ? FLUSH : IDLE;
               w_nxt_cnt    = FL_CNT;
            end else if (r_state == LDSTALL) begin
               w_stall = 1'b1;
               if (r_cnt == 2'd0) begin
                  w_nxt_state = IDLE;
               end else begin
                  w_nxt_cnt = r_cnt - 2'd1;
               end
            end else if (w_lu) begin
               w_stall     = 1'b1;
               w_nxt_state = LD_MULTI ? LDSTALL : IDLE;
               w_nxt_cnt   = LD_CNT;
            end
         end
         FLUSH: begin
            w_ifid_flush = 1'b1;
            if (redirect) begin
               w_idex_flush = 1'b1;
               w_nxt_cnt    = FL_CNT;
            end else if (r_cnt == 2'd0) begin
               w_nxt_state = IDLE;
            end else begin
               w_nxt_cnt = r_cnt - 2'd1;
            end
         end
         default: begin
            w_nxt_state = IDLE;
            w_nxt_cnt   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_busy  <= (w_nxt_state != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= '0;
      end else if (perf_clr) begin
         r_stall_cycles <= '0;
      end else if (w_stall && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   // Comb outputs see live ID/EX inputs, so they are gated to stay quiet while reset is held.
   assign pc_stall     = rst & w_stall;
   assign ifid_stall   = rst & w_stall;
   assign idex_bubble  = rst & w_stall;
   assign ifid_flush   = rst & w_ifid_flush;
   assign idex_flush   = rst & w_idex_flush;
   assign fwd1_sel     = rst ? w_fwd1 : FWD_RF;
   assign fwd2_sel     = rst ? w_fwd2 : FWD_RF;
   assign busy         = r_busy;
   assign stall_cycles = r_stall_cycles;

endmodule
